// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the NOP word, FSM states, FIFO entry layout and branch decode helper.
package fetch_pkg;

    localparam logic [31:0] NOP = 32'hE320_F000;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic is_branch(input logic [31:0] instr);
        return instr[27:25] == 3'b101;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two depth synchronous FIFO of fetched words with their PCs.
// Flush clears pointers and count, so stale entries can never reach the head.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever observed while count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake
// and queues returned words so a downstream stall never loses an instruction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        branch_out,
    output logic [31:0] pc_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic [31:0]   target, target_nxt;
    logic [31:0]   redirect_tgt;
    logic          req;
    logic          push, pop, flush;
    logic          full, empty;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        target_nxt = target;
        req        = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state)
            FETCH: begin
                req = (count < CW'(FIFO_DEPTH));
                if (redirect) begin
                    flush = 1'b1;
                    // An unacked request cannot be withdrawn; park the target until it returns.
                    if (req && !imem_ack) begin
                        target_nxt = redirect_tgt;
                        state_nxt  = DRAIN;
                    end else begin
                        pc_nxt = redirect_tgt;
                    end
                end else if (req && imem_ack) begin
                    push   = 1'b1;
                    pc_nxt = pc + 32'd4;
                end
            end
            DRAIN: begin
                req = 1'b1;
                if (redirect) begin
                    flush      = 1'b1;
                    target_nxt = redirect_tgt;
                end
                if (imem_ack) begin
                    pc_nxt    = redirect ? redirect_tgt : target;
                    state_nxt = FETCH;
                end
            end
            default: ;
        endcase
    end

    assign pop       = !sel_stall && !empty && !flush;
    assign imem_req  = req && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            target <= RESET_PC;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            target <= target_nxt;
        end
    end

    instr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data ('{instr: imem_rdata, pc: pc}),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign instr_out  = empty ? NOP   : head.instr;
    assign branch_out = !empty && is_branch(head.instr);
    assign pc_out     = empty ? 32'd0 : head.pc;

    ack_while_full: assert property (@(posedge clk) disable iff (rst)
        !(state == FETCH && imem_ack && full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory acks on an
// enable, and each cycle's outputs are compared with hand-derived values.
module tb_fetch_unit;

    localparam logic [31:0] NOP_W = 32'hE320_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        branch_out;
    logic [31:0] pc_out;
    logic        ack_en;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel_stall   (sel_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .branch_out  (branch_out),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    // Word at 0x10 is a branch; every other address holds a data-processing word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr == 32'h10) ? 32'hEA00_0004 : {8'hE2, addr[23:0]};
    endfunction

    assign imem_ack   = ack_en && imem_req;
    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check({tag, ".instr"}, instr_out, mem_word(pc));
        check({tag, ".pc"}, pc_out, pc);
    endtask

    task automatic expect_nop(input string tag);
        check({tag, ".instr"}, instr_out, NOP_W);
        check({tag, ".pc"}, pc_out, 32'd0);
        check({tag, ".br"}, {31'd0, branch_out}, 32'd0);
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        check({tag, ".req"}, {31'd0, imem_req}, 32'd1);
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        sel_stall   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        ack_en      = 1'b1;
        #1;
        check("rst.req", {31'd0, imem_req}, 32'd0);
        expect_nop("rst");
        tick;
        tick;
        rst = 1'b0;
        #1;

        // Streaming with same-cycle acks.
        expect_fetch("s0", 32'h0);
        expect_nop("s0");
        tick;
        expect_fetch("s1", 32'h4);
        expect_head("s1", 32'h0);
        for (int k = 2; k < 5; k++) begin
            tick;
            expect_head("s", 32'(k - 1) * 32'd4);
        end
        check("dp.br", {31'd0, branch_out}, 32'd0);
        tick;
        expect_head("b", 32'h10);
        check("b.br", {31'd0, branch_out}, 32'd1);

        // Stall until the queue fills, then drain in order.
        tick;
        expect_head("st0", 32'h14);
        sel_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("st.req", {31'd0, imem_req}, 32'd0);
            expect_head("st", 32'h14);
        end
        sel_stall = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick;
            expect_head("rel", 32'h14 + 32'(k) * 32'd4);
        end

        // Asynchronous reset while the queue holds data.
        sel_stall = 1'b1;
        tick;
        expect_head("full", 32'h20);
        rst = 1'b1;
        #1;
        check("arst.req", {31'd0, imem_req}, 32'd0);
        expect_nop("arst");
        sel_stall = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;

        // Redirect while the request to 0x8 is unacked, retargeted once in DRAIN.
        expect_fetch("d0", 32'h0);
        tick;
        expect_head("d1", 32'h0);
        tick;
        expect_fetch("d2", 32'h8);
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick;
        redirect = 1'b0;
        expect_fetch("d3", 32'h8);
        expect_nop("d3");
        tick;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        expect_fetch("d4", 32'h8);
        tick;
        redirect = 1'b0;
        ack_en   = 1'b1;
        expect_fetch("d5", 32'h8);
        expect_nop("d5");
        tick;
        expect_fetch("d6", 32'h100);
        expect_nop("d6");
        tick;
        expect_head("d7", 32'h100);

        // Redirect coinciding with an ack while one entry is queued.
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick;
        redirect = 1'b0;
        expect_fetch("r0", 32'h200);
        expect_nop("r0");
        tick;
        expect_head("r1", 32'h200);

        // Enter DRAIN, then reset mid-cycle.
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect = 1'b0;
        expect_fetch("dr", 32'h204);
        expect_nop("dr");
        #2;
        rst = 1'b1;
        #1;
        check("drst.req", {31'd0, imem_req}, 32'd0);
        expect_nop("drst");
        tick;
        rst    = 1'b0;
        ack_en = 1'b1;
        #1;
        expect_fetch("w0", 32'h0);

        // Same-cycle acked redirect to the top word, then PC wrap.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect = 1'b0;
        expect_fetch("w1", 32'hFFFF_FFFC);
        expect_nop("w1");
        tick;
        expect_fetch("w2", 32'h0);
        expect_head("w2", 32'hFFFF_FFFC);
        tick;
        expect_head("w3", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Sits directly upstream of the decode/execute pipeline register and feeds its instr_in and branch_in inputs.
- Owns the PC and runs a single-outstanding request/ack handshake to instruction memory.
- Buffers returned words in a small FIFO so a downstream stall never loses data.
- Handles branch redirects by flushing the FIFO and discarding any in-flight word.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction queue entries; power of two, >= 2.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- sel_stall  in  1  downstream stall; 1 = head not consumed this cycle.
- redirect  in  1  branch resolved taken; one-cycle pulse.
- redirect_pc  in  32  branch target, valid with redirect.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and not acked.
- imem_ack  in  1  memory returns imem_rdata this cycle; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  fetched instruction word.
- instr_out  out  32  instruction to decode; NOP when FIFO empty.
- branch_out  out  1  1 when head instruction is a B/BL (instr[27:25]==3'b101); 0 when empty.
- pc_out  out  32  PC of head entry; 0 when empty.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC, FIFO empty, FSM=FETCH, imem_req=0.
  - instr_out=NOP (32'hE320_F000), branch_out=0, pc_out=0.
  - Takes effect immediately, mid-transaction included; any pending request is abandoned.
- Outputs come from FIFO head registers only; there is no combinational path from imem_rdata to instr_out.
- Minimum latency: an ack at edge N makes the word visible on instr_out after edge N (cycle N+1).
- Issue rule: imem_req=1 in FETCH when (count + outstanding) < FIFO_DEPTH. At most one request outstanding. imem_addr=PC.
- Ack: the word is pushed with its PC, and PC <= PC+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
- Pop: head is consumed at a clock edge when sel_stall=0 and the FIFO is non-empty.
- Push and pop in the same cycle are allowed with the FIFO full; count is unchanged.
- Empty FIFO with sel_stall=0: NOP is presented, nothing is popped.
- FSM states:
  - FETCH: normal operation.
    - redirect with no request pending, or acked the same cycle -> FIFO flushed, PC <= redirect_pc, stay FETCH; any same-cycle ack data is discarded.
    - redirect with request pending and not acked -> FIFO flushed, target saved, go to DRAIN.
  - DRAIN: imem_req held with the old address until ack (the request cannot be cancelled). Returned data is discarded. On ack: PC <= saved target -> FETCH.
    - A further redirect in DRAIN overwrites the saved target.
- Priority: redirect > push/pop. Flush empties the FIFO regardless of sel_stall. The cycle after a redirect shows NOP.
- The flush is done by resetting the FIFO pointers; stale entries are never visible on the outputs.
- Redirect target low bits: redirect_pc[1:0] are forced to 0.
- Count never exceeds FIFO_DEPTH. An ack while full is impossible by the issue rule and is an assertion failure.

Decomposition:
- Package fetch_pkg holds:
  - NOP constant 32'hE320_F000.
  - fetch_state_t enum {FETCH, DRAIN}.
  - fetch_entry_t struct {instr[31:0], pc[31:0]}.
  - is_branch function (instr[27:25]==3'b101).
- One sub-module, instr_fifo: parameterised-depth synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count.
- fetch_unit contains the PC, the FSM and the handshake logic.

Test Plan:
- Reset release, memory acks same cycle, sel_stall=0 -> imem_addr sequence 0,4,8,…; instr_out shows word@0 the cycle after its ack; the first output cycle shows NOP.
- sel_stall=1 for 5 cycles with continuous acks -> FIFO fills to 2, imem_req drops. On release, words are delivered in order with no loss or duplication.
- redirect to 32'h100 while a request to 32'h8 is unacked and ack arrives 3 cycles later -> data from 32'h8 is discarded; the next imem_addr is 32'h100; instr_out is NOP until word@0x100 arrives.
- redirect in the same cycle as ack with FIFO holding 1 entry -> FIFO empties, the acked word is dropped, the next request is to the target.
- Branch word 32'hEA00_0004 fetched -> branch_out=1 while it is head. A data-processing word gives branch_out=0; an empty FIFO gives branch_out=0.
- rst asserted mid-DRAIN -> outputs return to reset values asynchronously; after release the first imem_addr is RESET_PC; PC wrap at 32'hFFFF_FFFC -> next address 0.
